// File: rtl/mux_scan_reg.sv
// mux_scan_reg
// Registered N_CH-channel, W-bit multiplexer with a valid/ready output.
// The channel comes either from a manual select or from an auto-scan
// round-robin. The scan dwells DWELL accepted beats on each channel and
// skips channels that are masked off in ch_en.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-low (0 = reset)
//   mode       0 = manual select, 1 = auto-scan
//   sel_in     manual channel index
//   ch_en      per-channel enable mask
//   data_in    packed channel data, channel i = data_in[i*W +: W]
//   out_ready  downstream accepts the current beat
//   out_valid  out_data/out_sel hold a valid beat
//   out_data   selected channel data (registered)
//   out_sel    index of the channel in out_data
//   out_onehot 1<<out_sel when out_valid, else 0 (only with MUX_SCAN_ONEHOT_EN)
//
// Optional feature macro: MUX_SCAN_ONEHOT_EN adds the out_onehot port.
module mux_scan_reg #(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int DWELL = 16,
    parameter int W_SEL = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [W_SEL-1:0]  sel_in,
    input  logic [N_CH-1:0]   ch_en,
    input  logic [N_CH*W-1:0] data_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [W_SEL-1:0]  out_sel
`ifdef MUX_SCAN_ONEHOT_EN
    ,
    output logic [N_CH-1:0]   out_onehot
`endif
);

    localparam int DW = $clog2(DWELL + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [W_SEL-1:0] cur, cur_nxt, cur_upd;
    logic [DW-1:0]    dwell_cnt, dwell_eff, dwell_upd;
    logic             load, any_en, sel_ok, valid_nxt;
    logic [W-1:0]     data_nxt;
`ifdef MUX_SCAN_ONEHOT_EN
    logic [N_CH-1:0]  onehot_nxt;
`endif

    // First enabled channel at or after start, wrapping N_CH-1 -> 0.
    // Returns start itself when nothing is enabled, so cur holds.
    function automatic logic [W_SEL-1:0] find_en(input logic [W_SEL-1:0] start,
                                                 input logic [N_CH-1:0]  en);
        logic [W_SEL-1:0] res;
        logic             found;
        int               idx;
        res   = start;
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(start) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && en[idx]) begin
                res   = W_SEL'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [W_SEL-1:0] next_idx(input logic [W_SEL-1:0] idx);
        return (idx == W_SEL'(N_CH - 1)) ? '0 : idx + W_SEL'(1);
    endfunction

    // cur always holds the channel the next scan load should present.
    // In manual mode it shadows sel_in (clamped) so a switch to scan starts
    // from the last manual channel with a fresh dwell count.
    always_comb begin
        load      = !out_valid || out_ready;
        any_en    = |ch_en;
        sel_ok    = int'(sel_in) < N_CH;
        state_nxt = state;
        cur_nxt   = cur;
        cur_upd   = cur;
        dwell_eff = '0;
        dwell_upd = dwell_cnt;
        if (!mode) begin
            cur_nxt   = sel_in;
            cur_upd   = sel_ok ? sel_in : '0;
            dwell_upd = '0;
        end else if (!any_en) begin
            state_nxt = ST_IDLE;
            dwell_upd = '0;
        end else begin
            state_nxt = ST_RUN;
            if (state == ST_RUN && ch_en[cur]) begin
                cur_nxt   = cur;
                dwell_eff = dwell_cnt;
            end else begin
                // Entering RUN or current channel was masked off: restart dwell
                cur_nxt   = find_en(cur, ch_en);
                dwell_eff = '0;
            end
            if (dwell_eff == DW'(DWELL - 1)) begin
                cur_upd   = find_en(next_idx(cur_nxt), ch_en);
                dwell_upd = '0;
            end else begin
                cur_upd   = cur_nxt;
                dwell_upd = dwell_eff + DW'(1);
            end
        end
    end

    // Output mux; an out-of-range index yields zero data and no valid.
    always_comb begin
        data_nxt  = '0;
        valid_nxt = 1'b0;
`ifdef MUX_SCAN_ONEHOT_EN
        onehot_nxt = '0;
`endif
        for (int i = 0; i < N_CH; i++) begin
            if (cur_nxt == W_SEL'(i)) begin
                data_nxt  = data_in[i*W +: W];
                valid_nxt = ch_en[i];
`ifdef MUX_SCAN_ONEHOT_EN
                onehot_nxt[i] = ch_en[i];
`endif
            end
        end
    end

    // Everything advances only on a load, so backpressure freezes both the
    // output beat and the scan position.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            cur       <= '0;
            dwell_cnt <= '0;
            state     <= ST_IDLE;
`ifdef MUX_SCAN_ONEHOT_EN
            out_onehot <= '0;
`endif
        end else if (load) begin
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            out_sel   <= cur_nxt;
            cur       <= cur_upd;
            dwell_cnt <= dwell_upd;
            state     <= state_nxt;
`ifdef MUX_SCAN_ONEHOT_EN
            out_onehot <= onehot_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg
// Self-checking bench for mux_scan_reg. Two instances share the inputs:
// dut2 uses DWELL=2, dut3 uses DWELL=3. Expected beats are queued as
// stimulus is applied and popped when the registered output appears.
module tb_mux_scan_reg;

    typedef struct {
        logic       valid;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] onehot;
    } exp_t;

    localparam logic [31:0] DATA = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    logic        clk;
    logic        rst;
    logic        mode;
    logic [1:0]  sel_in;
    logic [3:0]  ch_en;
    logic [31:0] data_in;
    logic        out_ready;

    logic        out_valid2, out_valid3;
    logic [7:0]  out_data2, out_data3;
    logic [1:0]  out_sel2, out_sel3;
`ifdef MUX_SCAN_ONEHOT_EN
    logic [3:0]  out_onehot2, out_onehot3;
`endif

    exp_t sb_q[$];
    exp_t exp_v;
    logic [7:0] chan_val [4];
    int n_cmp;
    int n_fail;

    mux_scan_reg #(.N_CH(4), .W(8), .DWELL(2)) dut2 (
        .clk(clk), .rst(rst), .mode(mode), .sel_in(sel_in), .ch_en(ch_en),
        .data_in(data_in), .out_ready(out_ready), .out_valid(out_valid2),
        .out_data(out_data2), .out_sel(out_sel2)
`ifdef MUX_SCAN_ONEHOT_EN
        , .out_onehot(out_onehot2)
`endif
    );

    mux_scan_reg #(.N_CH(4), .W(8), .DWELL(3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode), .sel_in(sel_in), .ch_en(ch_en),
        .data_in(data_in), .out_ready(out_ready), .out_valid(out_valid3),
        .out_data(out_data3), .out_sel(out_sel3)
`ifdef MUX_SCAN_ONEHOT_EN
        , .out_onehot(out_onehot3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic v, input logic [1:0] s);
        exp_t e;
        e.valid  = v;
        e.sel    = s;
        e.data   = chan_val[s];
        e.onehot = v ? (4'b0001 << s) : 4'b0000;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        mode      = 1'b0;
        sel_in    = 2'd0;
        ch_en     = 4'h0;
        out_ready = 1'b1;
        data_in   = DATA;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mode      = 1'($urandom);
            sel_in    = 2'($urandom);
            ch_en     = 4'($urandom);
            data_in   = $urandom;
            out_ready = 1'($urandom);
            e.valid = 1'b0; e.sel = 2'd0; e.data = 8'h00; e.onehot = 4'h0;
            sb_q.push_back(e);
            tick();
            exp_v = sb_q.pop_front();
            n_cmp += 2;
            if ({out_valid2, out_sel2, out_data2} !== {exp_v.valid, exp_v.sel, exp_v.data}) begin
                n_fail++;
                $display("[TB] FAIL reset_d2 cyc%0d: got v=%0b sel=%0d data=%h, want v=%0b sel=%0d data=%h",
                         c, out_valid2, out_sel2, out_data2, exp_v.valid, exp_v.sel, exp_v.data);
            end
            if ({out_valid3, out_sel3, out_data3} !== {exp_v.valid, exp_v.sel, exp_v.data}) begin
                n_fail++;
                $display("[TB] FAIL reset_d3 cyc%0d: got v=%0b sel=%0d data=%h, want v=%0b sel=%0d data=%h",
                         c, out_valid3, out_sel3, out_data3, exp_v.valid, exp_v.sel, exp_v.data);
            end
        end
    endtask

    task automatic test_manual();
        logic [3:0] en_tab [3];
        logic [1:0] sel_tab [3];
        logic       v_tab [3];
        do_reset();
        en_tab  = '{4'hF, 4'hB, 4'hB};
        sel_tab = '{2'd2, 2'd2, 2'd0};
        v_tab   = '{1'b1, 1'b0, 1'b1};
        mode = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ch_en  = en_tab[c];
            sel_in = sel_tab[c];
            push(v_tab[c], sel_tab[c]);
            tick();
            exp_v = sb_q.pop_front();
            n_cmp++;
            if ({out_valid2, out_sel2, out_data2} !== {exp_v.valid, exp_v.sel, exp_v.data}) begin
                n_fail++;
                $display("[TB] FAIL manual step%0d: got v=%0b sel=%0d data=%h, want v=%0b sel=%0d data=%h",
                         c, out_valid2, out_sel2, out_data2, exp_v.valid, exp_v.sel, exp_v.data);
            end
        end
    endtask

    task automatic test_scan();
        logic [1:0] seq [12];
        do_reset();
        seq   = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
        mode  = 1'b1;
        ch_en = 4'b1011;
        for (int c = 0; c < 12; c++) begin
            push(1'b1, seq[c]);
            tick();
            exp_v = sb_q.pop_front();
            n_cmp++;
            if ({out_valid3, out_sel3, out_data3} !== {exp_v.valid, exp_v.sel, exp_v.data}) begin
                n_fail++;
                $display("[TB] FAIL scan beat%0d: got v=%0b sel=%0d data=%h, want v=%0b sel=%0d data=%h",
                         c, out_valid3, out_sel3, out_data3, exp_v.valid, exp_v.sel, exp_v.data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] seq [10];
        logic       rdy [10];
        do_reset();
        seq  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        rdy  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        mode  = 1'b1;
        ch_en = 4'hF;
        for (int c = 0; c < 10; c++) begin
            out_ready = rdy[c];
            // Inputs wander while stalled; the held beat must not change
            data_in = (rdy[c] == 1'b0) ? $urandom : DATA;
            push(1'b1, seq[c]);
            tick();
            exp_v = sb_q.pop_front();
            n_cmp++;
            if ({out_valid2, out_sel2, out_data2} !== {exp_v.valid, exp_v.sel, exp_v.data}) begin
                n_fail++;
                $display("[TB] FAIL backpressure step%0d: got v=%0b sel=%0d data=%h, want v=%0b sel=%0d data=%h",
                         c, out_valid2, out_sel2, out_data2, exp_v.valid, exp_v.sel, exp_v.data);
            end
        end
        data_in   = DATA;
        out_ready = 1'b1;
    endtask

    task automatic test_mask();
        logic [3:0] en_tab [17];
        logic [1:0] sel_tab [17];
        logic       v_tab [17];
        do_reset();
        en_tab  = '{4'h0, 4'h0, 4'h0, 4'h0,
                    4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4,
                    4'hF, 4'hB, 4'hB, 4'hB,
                    4'h0, 4'hF, 4'hF};
        sel_tab = '{2'd0, 2'd0, 2'd0, 2'd0,
                    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                    2'd2, 2'd3, 2'd3, 2'd0,
                    2'd0, 2'd0, 2'd0};
        v_tab   = '{1'b0, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b1, 1'b1,
                    1'b0, 1'b1, 1'b1};
        mode = 1'b1;
        for (int c = 0; c < 17; c++) begin
            ch_en = en_tab[c];
            push(v_tab[c], sel_tab[c]);
            tick();
            exp_v = sb_q.pop_front();
            n_cmp++;
            if (!exp_v.valid) begin
                if (out_valid2 !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL mask_idle step%0d: got v=%0b, want v=0", c, out_valid2);
                end
            end else if ({out_valid2, out_sel2, out_data2} !== {exp_v.valid, exp_v.sel, exp_v.data}) begin
                n_fail++;
                $display("[TB] FAIL mask step%0d: got v=%0b sel=%0d data=%h, want v=%0b sel=%0d data=%h",
                         c, out_valid2, out_sel2, out_data2, exp_v.valid, exp_v.sel, exp_v.data);
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [1:0] seq [6];
        logic       md [6];
        do_reset();
        seq    = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};
        md     = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        sel_in = 2'd3;
        ch_en  = 4'hF;
        for (int c = 0; c < 6; c++) begin
            mode = md[c];
            push(1'b1, seq[c]);
            tick();
            exp_v = sb_q.pop_front();
            n_cmp++;
            if ({out_valid2, out_sel2, out_data2} !== {exp_v.valid, exp_v.sel, exp_v.data}) begin
                n_fail++;
                $display("[TB] FAIL mode_switch step%0d: got v=%0b sel=%0d data=%h, want v=%0b sel=%0d data=%h",
                         c, out_valid2, out_sel2, out_data2, exp_v.valid, exp_v.sel, exp_v.data);
            end
`ifdef MUX_SCAN_ONEHOT_EN
            n_cmp++;
            if (out_onehot2 !== exp_v.onehot) begin
                n_fail++;
                $display("[TB] FAIL onehot step%0d: got %b, want %b", c, out_onehot2, exp_v.onehot);
            end
`endif
        end
    endtask

    initial begin
        chan_val  = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b0;
        mode      = 1'b0;
        sel_in    = 2'd0;
        ch_en     = 4'h0;
        data_in   = DATA;
        out_ready = 1'b1;
        test_reset();
        test_manual();
        test_scan();
        test_backpressure();
        test_mask();
        test_mode_switch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
